// File: rtl/frame_buf_pingpong_if.sv
// Writer (s1, back bank) and display (s2, front bank) memory ports of the ping-pong buffer.
// chipselect is the request strobe; there is no backpressure, so every selected cycle is accepted.
interface frame_buf_pingpong_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] s1_address;
    logic              s1_chipselect;
    logic              s1_write;
    logic [DATA_W-1:0] s1_writedata;
    logic [BE_W-1:0]   s1_byteenable;
    logic [DATA_W-1:0] s1_readdata;

    logic [ADDR_W-1:0] s2_address;
    logic              s2_chipselect;
    logic [DATA_W-1:0] s2_readdata;
    logic              s2_readdatavalid;

    modport master (
        output s1_address, s1_chipselect, s1_write, s1_writedata, s1_byteenable,
        output s2_address, s2_chipselect,
        input  s1_readdata, s2_readdata, s2_readdatavalid
    );

    modport slave (
        input  s1_address, s1_chipselect, s1_write, s1_writedata, s1_byteenable,
        input  s2_address, s2_chipselect,
        output s1_readdata, s2_readdata, s2_readdatavalid
    );
endinterface

// File: rtl/frame_buf_pingpong.sv
// Double-buffered frame store: s1 fills the back bank while s2 displays the front bank.
// A swap FSM flips the banks on request, optionally deferred to the next vsync.
module frame_buf_pingpong #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 14,
    parameter int SWAP_MODE = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    frame_buf_pingpong_if.slave bus,
    input  logic                swap_req,
    input  logic                vsync,
    output logic                swap_ack,
    output logic                front_sel,
    output logic [1:0]          dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   commit;

    // Both banks share one array; the bank index is the top address bit.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic              back_sel;
    logic              s1_wr;
    logic              s1_rd;
    logic              s1_v1;
    logic [DATA_W-1:0] s1_d1;
    logic              s2_v1;
    logic [DATA_W-1:0] s2_d1;

    assign back_sel  = ~front_sel;
    assign s1_wr     = bus.s1_chipselect & bus.s1_write;
    assign s1_rd     = bus.s1_chipselect & ~bus.s1_write;
    assign dbg_state = state;

    // A write in the COMMIT cycle still sees the old front_sel, so it lands in the pre-swap back bank.
    always_ff @(posedge clk_clk) begin
        if (s1_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.s1_byteenable[b])
                    mem[{back_sel, bus.s1_address}][b*8 +: 8] <= bus.s1_writedata[b*8 +: 8];
            end
        end
    end

    // Bank is resolved in the request cycle, so in-flight reads are immune to a later swap.
    always_ff @(posedge clk_clk) begin
        s1_d1 <= mem[{back_sel, bus.s1_address}];
        s2_d1 <= mem[{front_sel, bus.s2_address}];
        if (reset_reset) begin
            s1_v1                <= 1'b0;
            s2_v1                <= 1'b0;
            bus.s1_readdata      <= '0;
            bus.s2_readdata      <= '0;
            bus.s2_readdatavalid <= 1'b0;
        end else begin
            s1_v1                <= s1_rd;
            s2_v1                <= bus.s2_chipselect;
            bus.s2_readdatavalid <= s2_v1;
            if (s1_v1) bus.s1_readdata <= s1_d1;
            if (s2_v1) bus.s2_readdata <= s2_d1;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req) state_nxt = (SWAP_MODE == 0) ? COMMIT : PENDING;
            end
            PENDING: begin
                if (vsync) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            swap_ack <= commit;
            if (commit) front_sel <= ~front_sel;
        end
    end
endmodule

// File: doc/frame_buf_pingpong.md
FRAME_BUF_PINGPONG -- requirements
Module: frame_buf_pingpong

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 14: word address width; each bank holds 2**ADDR_W words.
REQ-003 Parameter SWAP_MODE, default 1: 0 = swap on request, 1 = swap gated by vsync.
REQ-004 Derived BE_W = DATA_W/8 SHALL size all byteenable ports.
REQ-005 clk_clk  in  1  single clock; one clock; all logic rising-edge.
REQ-006 reset_reset  in  1  reset is synchronous and active-high.
REQ-007 s1_address  in  ADDR_W  writer-port word address (back bank).
REQ-008 s1_chipselect  in  1  writer-port access qualifier.
REQ-009 s1_write  in  1  1 = write, 0 = read, when selected.
REQ-010 s1_writedata  in  DATA_W  write data.
REQ-011 s1_byteenable  in  BE_W  per-byte write enable.
REQ-012 s1_readdata  out  DATA_W  back-bank read data.
REQ-013 s2_address  in  ADDR_W  display-port word address (front bank).
REQ-014 s2_chipselect  in  1  display-port read request.
REQ-015 s2_readdata  out  DATA_W  front-bank read data.
REQ-016 s2_readdatavalid  out  1  qualifies s2_readdata for one cycle.
REQ-017 swap_req  in  1  single-cycle pulse requesting a bank swap.
REQ-018 vsync  in  1  single-cycle frame-boundary pulse (used when SWAP_MODE=1).
REQ-019 swap_ack  out  1  one-cycle pulse in the cycle after a swap commits.
REQ-020 front_sel  out  1  index of the bank currently displayed (0 or 1).

Function
REQ-021 Two banks of 2**ADDR_W x DATA_W; s1 SHALL address bank ~front_sel, s2 SHALL address bank front_sel.
REQ-022 s1 write (chipselect=1, write=1) SHALL update only bytes whose byteenable bit is 1; byteenable all-zero SHALL leave memory unchanged.
REQ-023 s1 read SHALL have fixed latency 2: s1_readdata valid 2 cycles after the request cycle; s1_readdata holds its last value otherwise.
REQ-024 s2 read SHALL have fixed latency 2; s2_readdatavalid SHALL be 1 exactly 2 cycles after each cycle with s2_chipselect=1, and 0 otherwise.
REQ-025 Both ports SHALL accept one access per cycle with no stall; back-to-back reads SHALL pipeline.
REQ-026 A read in flight SHALL return data from the bank selected in its request cycle, even if a swap commits before data returns.
REQ-027 Swap FSM states: IDLE, PENDING, COMMIT.
REQ-028 IDLE: swap_req=1 -> COMMIT if SWAP_MODE=0; -> PENDING if SWAP_MODE=1 (vsync in the same cycle does NOT commit).
REQ-029 PENDING: vsync=1 -> COMMIT; swap_req while PENDING SHALL be absorbed (no second swap).
REQ-030 COMMIT: front_sel SHALL toggle at the end of this cycle; next state IDLE; swap_ack=1 in the following cycle.
REQ-031 swap_req received in COMMIT SHALL be ignored.
REQ-032 An s1 write in the COMMIT cycle SHALL land in the pre-swap back bank (bank chosen by front_sel before toggle).
REQ-033 Same-address, same-bank collisions cannot occur (ports always target different banks); no arbitration required.
REQ-034 Address wrap: addresses are ADDR_W bits; no out-of-range condition exists.

Reset
REQ-035 reset_reset=1 at a rising edge SHALL force: FSM=IDLE, front_sel=0, swap_ack=0, s2_readdatavalid=0, s1_readdata=0, s2_readdata=0, read pipelines flushed.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 Reset mid-PENDING SHALL cancel the pending swap; reads in flight SHALL produce no readdatavalid after reset.

Verification
REQ-038 SWAP_MODE=1, reset; s1 write 0x1234 to addr 5 be=11; s2 read addr 5 -> readdatavalid after 2 cycles, data = 0 or uninit (front bank 0, not written); s1 read addr 5 -> 0x1234.
REQ-039 swap_req, vsync 3 cycles later -> front_sel 0->1 at commit, swap_ack pulses once the next cycle; s2 read addr 5 -> 0x1234.
REQ-040 s1 write 0xABCD addr 7 be=01 over existing 0x1111 -> s1 read returns 0x11CD; be=00 write leaves 0x11CD.
REQ-041 s2 reads streamed every cycle across a commit -> reads issued pre-commit return old-bank data, post-commit return new-bank data, readdatavalid continuous.
REQ-042 swap_req then reset before vsync -> front_sel stays 0, no swap_ack; later vsync alone causes no swap.
REQ-043 SWAP_MODE=0: two swap_req pulses 1 cycle apart -> exactly one toggle; pulses 3 cycles apart -> two toggles, front_sel returns to 0.
